// File: rtl/single_port_ram.sv
`default_nettype none
// ============================================================================
//  Module   : single_port_ram
//  Purpose  : Single-port RAM built from resettable flip-flops. One access per
//             clock: write (w=1, write-first so dout shows din) or read (w=0).
//             Read data is registered, giving one edge of latency.
//  Ports    : clk   - clock, all state changes on the rising edge
//             rst_n - asynchronous active-low reset (clears dout and memory)
//             din   - write data, DATA_W bits
//             addr  - word address for both read and write, ADDR_W bits
//             w     - 1 = write cycle, 0 = read cycle
//             dout  - registered read data, DATA_W bits
//  Revision : 1.0 - initial release
// ============================================================================
module single_port_ram #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] addr,
  input  logic              w,
  output logic [DATA_W-1:0] dout
);

  // Storage is flops rather than an inferred RAM so every word can be cleared
  // by the asynchronous reset.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;

  // One decoded write enable per word. Addresses at or beyond DEPTH match no
  // word, so writes to them fall on the floor.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem[i] <= '0;
        end else if (w && (addr == ADDR_W'(i))) begin
          mem[i] <= din;
        end
      end
    end
  endgenerate

  // Read mux. Defaulting to zero makes out-of-range addresses read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) begin
        rd_data = mem[i];
      end
    end
  end

  // Write-first output register: a write cycle presents din on dout at the
  // same edge the word is stored, so no bypass from mem is needed afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (w) begin
      dout <= din;
    end else begin
      dout <= rd_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_single_port_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_single_port_ram
//  Purpose  : Directed self-checking bench for single_port_ram with default
//             parameters (4-bit data, 32 words). Inputs change just after the
//             falling edge, outputs are checked on the following falling edge.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_single_port_ram;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] addr;
  logic              w;
  logic [DATA_W-1:0] dout;

  int n_assert;
  int n_fail;

  single_port_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .addr (addr),
    .w    (w),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one access and wait until the falling edge after its rising edge.
  task automatic access(input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    w    = wr;
    addr = a;
    din  = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] exp);
    n_assert++;
    assert (dout === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, dout, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    w        = 1'b0;
    addr     = '0;
    din      = '0;

    // Reset, asserted away from any clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_dout", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Every word reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      access(1'b0, ADDR_W'(i), 4'b0101);
      check($sformatf("reset_read_%0d", i), 4'b0000);
    end

    // Write-through and read-back.
    access(1'b1, 5'd3, 4'b1010);
    check("wr3_through", 4'b1010);
    access(1'b1, 5'd1, 4'b1001);
    check("wr1_through", 4'b1001);
    access(1'b0, 5'd3, 4'b0000);
    check("rd3", 4'b1010);

    // dout holds between edges while inputs move.
    w    = 1'b1;
    addr = 5'd7;
    din  = 4'b0111;
    #2 check("hold_between_edges", 4'b1010);

    // din ignored on read, word 1 unchanged.
    access(1'b0, 5'd1, 4'b0001);
    check("rd1_din_ignored", 4'b1001);
    access(1'b0, 5'd1, 4'b1111);
    check("rd1_again", 4'b1001);

    // Write then immediate read; neighbours untouched.
    access(1'b1, 5'd2, 4'b1100);
    check("wr2_through", 4'b1100);
    access(1'b0, 5'd2, 4'b0000);
    check("rd2_after_wr", 4'b1100);
    access(1'b0, 5'd1, 4'b0000);
    check("rd1_neighbour", 4'b1001);
    access(1'b0, 5'd3, 4'b0000);
    check("rd3_neighbour", 4'b1010);

    // Address boundaries.
    access(1'b1, 5'd31, 4'b1111);
    check("wr31_through", 4'b1111);
    access(1'b1, 5'd0, 4'b0110);
    check("wr0_through", 4'b0110);
    access(1'b0, 5'd31, 4'b0000);
    check("rd31", 4'b1111);
    access(1'b0, 5'd0, 4'b0000);
    check("rd0", 4'b0110);
    access(1'b0, 5'd30, 4'b0000);
    check("rd30_untouched", 4'b0000);

    // Reset pulse between edges after writes: dout clears at once.
    access(1'b0, 5'd2, 4'b0000);
    check("rd2_before_reset", 4'b1100);
    #2 rst_n = 1'b0;
    #1 check("reset_async_dout", 4'b0000);
    // A write attempted during reset must be ignored.
    w    = 1'b1;
    addr = 5'd1;
    din  = 4'b1110;
    @(posedge clk);
    @(negedge clk);
    check("reset_hold_dout", 4'b0000);
    rst_n = 1'b1;

    access(1'b0, 5'd1, 4'b0000);
    check("post_reset_rd1", 4'b0000);
    access(1'b0, 5'd2, 4'b0000);
    check("post_reset_rd2", 4'b0000);
    access(1'b0, 5'd3, 4'b0000);
    check("post_reset_rd3", 4'b0000);
    access(1'b0, 5'd31, 4'b0000);
    check("post_reset_rd31", 4'b0000);

    // Normal operation resumes after reset.
    access(1'b1, 5'd5, 4'b1001);
    check("post_reset_wr5", 4'b1001);
    access(1'b0, 5'd5, 4'b0000);
    check("post_reset_rd5", 4'b1001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
